// File: rtl/divider_8_req_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// divider_8_req_sequencer_pkg
// Shared definitions for the divider request sequencer: FSM state encoding,
// result error codes and a helper that classifies the divider wait states.
// ---------------------------------------------------------------------------
package divider_8_req_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_ACK    = 3'd4,
        ST_RESULT = 3'd5
    } seq_state_e;

    localparam logic [1:0] RES_ERR_OK      = 2'b00;
    localparam logic [1:0] RES_ERR_DIV0    = 2'b01;
    localparam logic [1:0] RES_ERR_TIMEOUT = 2'b10;

    // States in which the sequencer is waiting on the divider and the
    // watchdog must run.
    function automatic logic is_div_wait(input seq_state_e s);
        return (s == ST_ARM) || (s == ST_START) || (s == ST_WAIT) || (s == ST_ACK);
    endfunction

endpackage

// File: rtl/divider_8_req_sequencer_watchdog.sv
// ---------------------------------------------------------------------------
// div_watchdog
// Counts cycles spent in a divider wait state and flags expiry once the count
// reaches TIMEOUT_CYCLES.
//   ClkPort  in  clock
//   Reset    in  asynchronous active-high reset
//   clr      in  clear count (has priority over en)
//   en       in  count this cycle
//   expired  out count has reached TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module div_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic ClkPort,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    assign expired = (cnt_q == LIMIT);

    // Hold at the limit so the count can never wrap back below it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/divider_8_req_sequencer.sv
// ---------------------------------------------------------------------------
// divider_8_req_sequencer
// Feeds operand pairs to the 8-bit PicoBlaze divider through its Xin/Yin,
// Start/Ack level handshake and returns Quotient/Remainder on a valid/ready
// result port. Y=0 is answered locally; every divider wait is watchdogged.
//   ClkPort, Reset                 clock, async active-high reset
//   op_valid/op_ready/op_x/op_y    operand request interface
//   Xin, Yin, Start, Ack           outputs to the divider
//   Qi, Qd, Done, Quotient, Remainder  inputs from the divider
//   res_valid/res_ready/res_quotient/res_remainder/res_err  result interface
// ---------------------------------------------------------------------------
module divider_8_req_sequencer
    import divider_8_req_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic       ClkPort,
    input  logic       Reset,
    input  logic       op_valid,
    input  logic [7:0] op_x,
    input  logic [7:0] op_y,
    output logic       op_ready,
    output logic [7:0] Xin,
    output logic [7:0] Yin,
    output logic       Start,
    output logic       Ack,
    input  logic       Qi,
    input  logic       Qd,
    input  logic       Done,
    input  logic [7:0] Quotient,
    input  logic [7:0] Remainder,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_quotient,
    output logic [7:0] res_remainder,
    output logic [1:0] res_err
);

    seq_state_e state_q, state_d;
    logic [7:0] xin_q, xin_d;
    logic [7:0] yin_q, yin_d;
    logic       start_q, start_d;
    logic       ack_q, ack_d;
    logic       res_valid_q, res_valid_d;
    logic [7:0] res_quo_q, res_quo_d;
    logic [7:0] res_rem_q, res_rem_d;
    logic [1:0] res_err_q, res_err_d;

    logic wd_clr;
    logic wd_en;
    logic wd_expired;

    // Watchdog restarts on every state change and runs only in divider waits.
    assign wd_clr = (state_d != state_q);
    assign wd_en  = is_div_wait(state_q);

    div_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_watchdog (
        .ClkPort(ClkPort),
        .Reset  (Reset),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        xin_d       = xin_q;
        yin_d       = yin_q;
        start_d     = start_q;
        ack_d       = ack_q;
        res_valid_d = res_valid_q;
        res_quo_d   = res_quo_q;
        res_rem_d   = res_rem_q;
        res_err_d   = res_err_q;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    xin_d = op_x;
                    yin_d = op_y;
                    if (op_y == 8'd0) begin
                        state_d     = ST_RESULT;
                        res_valid_d = 1'b1;
                        res_quo_d   = 8'hFF;
                        res_rem_d   = op_x;
                        res_err_d   = RES_ERR_DIV0;
                    end else begin
                        state_d = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                if (Qi) begin
                    state_d = ST_START;
                    start_d = 1'b1;
                end
            end
            ST_START: begin
                // Qi falling means the divider has left its initial state.
                if (!Qi) begin
                    state_d = ST_WAIT;
                    start_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (Done && Qd) begin
                    state_d   = ST_ACK;
                    ack_d     = 1'b1;
                    res_quo_d = Quotient;
                    res_rem_d = Remainder;
                    res_err_d = RES_ERR_OK;
                end
            end
            ST_ACK: begin
                if (Qi) begin
                    state_d     = ST_RESULT;
                    ack_d       = 1'b0;
                    res_valid_d = 1'b1;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                start_d     = 1'b0;
                ack_d       = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase

        // Abort overrides whatever the wait state decided this cycle.
        if (wd_expired && is_div_wait(state_q)) begin
            state_d     = ST_RESULT;
            start_d     = 1'b0;
            ack_d       = 1'b0;
            res_valid_d = 1'b1;
            res_quo_d   = 8'h00;
            res_rem_d   = 8'h00;
            res_err_d   = RES_ERR_TIMEOUT;
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            xin_q       <= 8'h00;
            yin_q       <= 8'h00;
            start_q     <= 1'b0;
            ack_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_quo_q   <= 8'h00;
            res_rem_q   <= 8'h00;
            res_err_q   <= RES_ERR_OK;
        end else begin
            state_q     <= state_d;
            xin_q       <= xin_d;
            yin_q       <= yin_d;
            start_q     <= start_d;
            ack_q       <= ack_d;
            res_valid_q <= res_valid_d;
            res_quo_q   <= res_quo_d;
            res_rem_q   <= res_rem_d;
            res_err_q   <= res_err_d;
        end
    end

    assign op_ready      = (state_q == ST_IDLE);
    assign Xin           = xin_q;
    assign Yin           = yin_q;
    assign Start         = start_q;
    assign Ack           = ack_q;
    assign res_valid     = res_valid_q;
    assign res_quotient  = res_quo_q;
    assign res_remainder = res_rem_q;
    assign res_err       = res_err_q;

endmodule

// File: tb/tb_divider_8_req_sequencer.sv
// ---------------------------------------------------------------------------
// Directed bench for divider_8_req_sequencer with a behavioural divider
// stand-in (flags Qi/Qd/Done, configurable latency or hang).
// ---------------------------------------------------------------------------
module tb_divider_8_req_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic [7:0] op_x;
    logic [7:0] op_y;
    logic       op_ready;
    logic [7:0] Xin;
    logic [7:0] Yin;
    logic       Start;
    logic       Ack;
    logic       Qi;
    logic       Qd;
    logic       Done;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_quotient;
    logic [7:0] res_remainder;
    logic [1:0] res_err;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    divider_8_req_sequencer #(
        .TIMEOUT_CYCLES(4096),
        .TO_W          (13)
    ) dut (
        .ClkPort      (clk),
        .Reset        (rst),
        .op_valid     (op_valid),
        .op_x         (op_x),
        .op_y         (op_y),
        .op_ready     (op_ready),
        .Xin          (Xin),
        .Yin          (Yin),
        .Start        (Start),
        .Ack          (Ack),
        .Qi           (Qi),
        .Qd           (Qd),
        .Done         (Done),
        .Quotient     (Quotient),
        .Remainder    (Remainder),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_quotient (res_quotient),
        .res_remainder(res_remainder),
        .res_err      (res_err)
    );

    // Divider stand-in: leaves initial state on Start, finishes after m_lat
    // cycles (never when m_hang), returns to initial state on Ack.
    logic m_hang = 1'b0;
    int   m_lat  = 5;
    logic m_busy;
    int   m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            Qi        <= 1'b1;
            Qd        <= 1'b0;
            Done      <= 1'b0;
            m_busy    <= 1'b0;
            m_cnt     <= 0;
            Quotient  <= 8'h00;
            Remainder <= 8'h00;
        end else if (Qi && Start && !m_busy && !Qd) begin
            Qi     <= 1'b0;
            m_busy <= 1'b1;
            m_cnt  <= m_lat;
            if (Yin != 8'd0) begin
                Quotient  <= Xin / Yin;
                Remainder <= Xin % Yin;
            end
        end else if (m_busy && !m_hang) begin
            if (m_cnt == 0) begin
                m_busy <= 1'b0;
                Qd     <= 1'b1;
                Done   <= 1'b1;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (Qd && Ack) begin
            Qd   <= 1'b0;
            Done <= 1'b0;
            Qi   <= 1'b1;
        end
    end

    int overlap_cnt = 0;
    int start_seen  = 0;

    always @(negedge clk) begin
        if (Start && Ack) overlap_cnt++;
        if (Start) start_seen++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_res(input string name, input int budget);
        int n = 0;
        while (res_valid !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (res_valid !== 1'b1) $display("FAIL %s: res_valid not seen within %0d cycles", name, budget);
        else passed++;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        step(1);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || op_ready !== 1'b1)
            $display("FAIL consume: res_valid=%b op_ready=%b expected 0/1", res_valid, op_ready);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        op_valid = 1'b0; op_x = 8'h00; op_y = 8'h00; res_ready = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        checks++;
        if (op_ready !== 1'b1 || Start !== 1'b0 || Ack !== 1'b0 || res_valid !== 1'b0)
            $display("FAIL reset_ctrl: op_ready=%b Start=%b Ack=%b res_valid=%b expected 1/0/0/0",
                     op_ready, Start, Ack, res_valid);
        else passed++;
        checks++;
        if (Xin !== 8'h00 || Yin !== 8'h00 || res_quotient !== 8'h00 || res_remainder !== 8'h00 || res_err !== 2'b00)
            $display("FAIL reset_data: Xin=%h Yin=%h Q=%h R=%h err=%b expected all zero",
                     Xin, Yin, res_quotient, res_remainder, res_err);
        else passed++;
    endtask

    task automatic test_divide_100_7();
        int n = 0;
        m_lat = 5;
        op_x = 8'd100; op_y = 8'd7; op_valid = 1'b1;
        step(1);
        op_valid = 1'b0;
        checks++;
        if (Start !== 1'b0 || op_ready !== 1'b0)
            $display("FAIL accept_arm: Start=%b op_ready=%b expected 0/0", Start, op_ready);
        else passed++;
        step(1);
        checks++;
        if (Start !== 1'b1) $display("FAIL start_latency: Start=%b expected 1 two cycles after accept", Start);
        else passed++;
        wait_res("div_100_7", 200);
        checks++;
        if (res_quotient !== 8'd14 || res_remainder !== 8'd2 || res_err !== 2'b00)
            $display("FAIL div_100_7: Q=%0d R=%0d err=%b expected 14 2 00", res_quotient, res_remainder, res_err);
        else passed++;
        checks++;
        if (Xin !== 8'd100 || Yin !== 8'd7 || Start !== 1'b0 || Ack !== 1'b0)
            $display("FAIL div_100_7_hold: Xin=%0d Yin=%0d Start=%b Ack=%b expected 100 7 0 0", Xin, Yin, Start, Ack);
        else passed++;
        consume();
    endtask

    task automatic test_div_by_zero();
        int s0 = start_seen;
        op_x = 8'd5; op_y = 8'd0; op_valid = 1'b1;
        step(1);
        op_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_quotient !== 8'hFF || res_remainder !== 8'h05 || res_err !== 2'b01)
            $display("FAIL div0: valid=%b Q=%h R=%h err=%b expected 1 FF 05 01",
                     res_valid, res_quotient, res_remainder, res_err);
        else passed++;
        step(3);
        checks++;
        if (start_seen != s0) $display("FAIL div0_start: Start high %0d cycles, expected 0", start_seen - s0);
        else passed++;
        consume();
    endtask

    task automatic test_timeout_and_hold();
        int n = 0;
        int bad = 0;
        m_hang = 1'b1;
        op_x = 8'd50; op_y = 8'd5; op_valid = 1'b1;
        step(1);
        op_valid = 1'b0;
        while (Start !== 1'b1 && n < 10) begin step(1); n++; end
        n = 0;
        while (Start !== 1'b0 && n < 10) begin step(1); n++; end
        // Now just past the WAIT entry edge; the count reaches 4096 after
        // 4096 more edges and the abort lands on the edge after that.
        n = 0;
        while (res_valid !== 1'b1 && n < 5000) begin step(1); n++; end
        checks++;
        if (n != 4097) $display("FAIL timeout_cycles: res_valid after %0d cycles in WAIT expected 4097", n);
        else passed++;
        checks++;
        if (Start !== 1'b0 || Ack !== 1'b0 || res_quotient !== 8'h00 || res_remainder !== 8'h00 || res_err !== 2'b10)
            $display("FAIL timeout_result: Start=%b Ack=%b Q=%h R=%h err=%b expected 0 0 00 00 10",
                     Start, Ack, res_quotient, res_remainder, res_err);
        else passed++;
        // Hold result with a competing request present.
        op_x = 8'd77; op_y = 8'd7; op_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            step(1);
            if (res_valid !== 1'b1 || res_quotient !== 8'h00 || res_remainder !== 8'h00 ||
                res_err !== 2'b10 || op_ready !== 1'b0 || Xin !== 8'd50) bad++;
        end
        op_valid = 1'b0;
        checks++;
        if (bad != 0) $display("FAIL hold_result: %0d unstable cycles expected 0", bad);
        else passed++;
        consume();
        m_hang = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        int n = 0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        m_lat = 40;
        op_x = 8'd30; op_y = 8'd4; op_valid = 1'b1;
        step(1);
        op_valid = 1'b0;
        while (Start !== 1'b1 && n < 10) begin step(1); n++; end
        n = 0;
        while (Start !== 1'b0 && n < 10) begin step(1); n++; end
        step(5);
        checks++;
        if (op_ready !== 1'b0) $display("FAIL pre_reset_busy: op_ready=%b expected 0", op_ready);
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if (Start !== 1'b0 || Ack !== 1'b0 || res_valid !== 1'b0 || op_ready !== 1'b1 || Xin !== 8'h00)
            $display("FAIL async_reset: Start=%b Ack=%b res_valid=%b op_ready=%b Xin=%h expected 0 0 0 1 00",
                     Start, Ack, res_valid, op_ready, Xin);
        else passed++;
        step(2);
        rst = 1'b0;
        m_lat = 5;
        step(1);
        op_x = 8'd255; op_y = 8'd16; op_valid = 1'b1;
        step(1);
        op_valid = 1'b0;
        wait_res("div_255_16", 200);
        checks++;
        if (res_quotient !== 8'd15 || res_remainder !== 8'd15 || res_err !== 2'b00)
            $display("FAIL div_255_16: Q=%0d R=%0d err=%b expected 15 15 00", res_quotient, res_remainder, res_err);
        else passed++;
        consume();
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        int n = 0;
        m_lat = 3;
        op_x = 8'd200; op_y = 8'd3; op_valid = 1'b1;
        step(1);
        op_x = 8'd9; op_y = 8'd9;
        while (res_valid !== 1'b1 && n < 200) begin
            if (Xin !== 8'd200 || Yin !== 8'd3) bad++;
            step(1);
            n++;
        end
        checks++;
        if (res_valid !== 1'b1 || res_quotient !== 8'd66 || res_remainder !== 8'd2)
            $display("FAIL b2b_first: valid=%b Q=%0d R=%0d expected 1 66 2", res_valid, res_quotient, res_remainder);
        else passed++;
        checks++;
        if (bad != 0 || Xin !== 8'd200) $display("FAIL b2b_no_early_accept: %0d cycles Xin/Yin changed, Xin=%0d", bad, Xin);
        else passed++;
        res_ready = 1'b1;
        step(1);
        res_ready = 1'b0;
        checks++;
        if (op_ready !== 1'b1 || Xin !== 8'd200)
            $display("FAIL b2b_idle: op_ready=%b Xin=%0d expected 1 200", op_ready, Xin);
        else passed++;
        step(1);
        op_valid = 1'b0;
        checks++;
        if (Xin !== 8'd9 || Yin !== 8'd9 || op_ready !== 1'b0)
            $display("FAIL b2b_second_accept: Xin=%0d Yin=%0d op_ready=%b expected 9 9 0", Xin, Yin, op_ready);
        else passed++;
        wait_res("b2b_second", 200);
        checks++;
        if (res_quotient !== 8'd1 || res_remainder !== 8'd0 || res_err !== 2'b00)
            $display("FAIL b2b_second: Q=%0d R=%0d err=%b expected 1 0 00", res_quotient, res_remainder, res_err);
        else passed++;
        consume();
    endtask

    initial begin
        test_reset();
        test_divide_100_7();
        test_div_by_zero();
        test_timeout_and_hold();
        test_reset_in_wait();
        test_back_to_back();
        checks++;
        if (overlap_cnt != 0) $display("FAIL start_ack_overlap: %0d cycles with both high expected 0", overlap_cnt);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
